iterative_divider_64_32: RTL and testbench

ITERATIVE_DIVIDER_64_32 -- requirements
Module: iterative_divider_64_32

---
 rtl/iterative_divider_64_32.sv | 153 +++++++++++++++
 tb/tb_iterative_divider_64_32.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/iterative_divider_64_32.sv
// Restoring radix-2 divider: unsigned 2N-bit dividend by N-bit divisor, one quotient bit per clock.
// Zero divisor and quotient overflow are detected up front and finish without iterating.
module iterative_divider_64_32 #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] A,
  input  logic [N-1:0]   B,
  output logic [N-1:0]   Q,
  output logic [N-1:0]   R,
  output logic           busy,
  output logic           done,
  output logic           div_zero,
  output logic           ovf
);

  localparam int CW = $clog2(N);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;
  localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  p_q, p_d;
  logic [N-1:0]  qs_q, qs_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  r_q, r_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          dz_q, dz_d;
  logic          ovf_q, ovf_d;

  logic [N:0]    p_shift_s;
  logic [N:0]    diff_s;
  logic          ge_s;
  logic [N-1:0]  p_next_s;
  logic [N-1:0]  qs_next_s;

  // Trial subtraction: the stored remainder stays below B, so only the shifted-out MSB
  // can push P' past N bits, and in that case P' >= B unconditionally.
  always_comb begin
    p_shift_s = {p_q, qs_q[N-1]};
    diff_s    = {1'b0, p_shift_s[N-1:0]} - {1'b0, b_q};
    ge_s      = p_shift_s[N] | ~diff_s[N];
    if (ge_s) begin
      p_next_s = diff_s[N-1:0];
    end else begin
      p_next_s = p_shift_s[N-1:0];
    end
    qs_next_s = {qs_q[N-2:0], ge_s};
  end

  // Control FSM and datapath next-state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    qs_d    = qs_q;
    b_d     = b_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d = {CW{1'b0}};
          dz_d  = 1'b0;
          ovf_d = 1'b0;
          b_d   = B;
          if (B == {N{1'b0}}) begin
            dz_d    = 1'b1;
            q_d     = {N{1'b1}};
            r_d     = A[N-1:0];
            state_d = S_FIN;
          end else if (A[2*N-1:N] >= B) begin
            ovf_d   = 1'b1;
            q_d     = {N{1'b1}};
            r_d     = A[N-1:0];
            state_d = S_FIN;
          end else begin
            p_d     = A[2*N-1:N];
            qs_d    = A[N-1:0];
            state_d = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        p_d   = p_next_s;
        qs_d  = qs_next_s;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          q_d     = qs_next_s;
          r_d     = p_next_s;
          state_d = S_FIN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_FIN);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= {CW{1'b0}};
      p_q     <= {N{1'b0}};
      qs_q    <= {N{1'b0}};
      b_q     <= {N{1'b0}};
      q_q     <= {N{1'b0}};
      r_q     <= {N{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      qs_q    <= qs_d;
      b_q     <= b_d;
      q_q     <= q_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Q        = q_q;
  assign R        = r_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_iterative_divider_64_32.sv
// Scoreboard bench for iterative_divider_64_32: directed corner cases, reset abort and
// randomized operands with ignored start pulses, checked against an arithmetic model.
module tb_iterative_divider_64_32;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [63:0] A = 64'd0;
  logic [31:0] B = 32'd0;
  logic [31:0] Q, R;
  logic        busy, done, div_zero, ovf;

  typedef struct {
    logic [63:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        ov;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  iterative_divider_64_32 #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .Q(Q), .R(R), .busy(busy), .done(done), .div_zero(div_zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: plain division, with the two early-exit cases
  function automatic exp_t model(input logic [63:0] a, input logic [31:0] b, input int acc);
    exp_t e;
    e.a = a; e.b = b; e.dz = 1'b0; e.ov = 1'b0;
    if (b == 32'd0) begin
      e.dz = 1'b1; e.q = 32'hFFFF_FFFF; e.r = a[31:0]; e.due = acc;
    end else if (a[63:32] >= b) begin
      e.ov = 1'b1; e.q = 32'hFFFF_FFFF; e.r = a[31:0]; e.due = acc;
    end else begin
      e.q = 32'(a / {32'd0, b});
      e.r = 32'(a % {32'd0, b});
      e.due = acc + N;
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL extra_done: done at cycle %0d, expected no done", cyc);
      end else begin : pop_blk
        exp_t e;
        e = sb.pop_front();
        chk("latency", 64'(cyc), 64'(e.due));
        chk("Q", {32'd0, Q}, {32'd0, e.q});
        chk("R", {32'd0, R}, {32'd0, e.r});
        chk("div_zero", {63'd0, div_zero}, {63'd0, e.dz});
        chk("ovf", {63'd0, ovf}, {63'd0, e.ov});
        chk("busy_at_done", {63'd0, busy}, 64'd0);
        if (!e.dz && !e.ov) begin
          chk("invariant", {32'd0, Q} * {32'd0, e.b} + {32'd0, R}, e.a);
          chk("r_lt_b", {63'd0, (R < e.b)}, 64'd1);
        end
      end
    end else if (sb.size() != 0 && cyc > sb[0].due) begin
      total++; bad++;
      $display("FAIL late_done: no done by cycle %0d, expected at %0d", cyc, sb[0].due);
      void'(sb.pop_front());
    end
  end

  task automatic issue(input logic [63:0] a, input logic [31:0] b);
    @(negedge clk); #1;
    A = a; B = b; start = 1'b1;
    sb.push_back(model(a, b, cyc + 1));
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && sb.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run_op(input logic [63:0] a, input logic [31:0] b, input bit junk);
    exp_t e;
    e = model(a, b, 0);
    issue(a, b);
    if (junk && !e.dz && !e.ov) begin
      for (int i = 0; i < 30; i++) begin
        @(negedge clk); #1;
        start = 1'($urandom_range(1, 0));
        A = {$urandom, $urandom};
        B = $urandom;
      end
    end
    @(negedge clk); #1;
    start = 1'b0;
    drain();
    if (junk) begin
      start = 1'b1; A = {$urandom, $urandom}; B = $urandom;
    end
    @(negedge clk); #1;
    start = 1'b0;
    chk("hold_Q", {32'd0, Q}, {32'd0, e.q});
    chk("hold_R", {32'd0, R}, {32'd0, e.r});
    chk("hold_flags", {62'd0, div_zero, ovf}, {62'd0, e.dz, e.ov});
    chk("idle_busy", {63'd0, busy}, 64'd0);
  endtask

  task automatic chk_zero(input string name);
    chk(name, {Q, R}, 64'd0);
    chk(name, {60'd0, busy, done, div_zero, ovf}, 64'd0);
  endtask

  initial begin
    logic [31:0] b;
    logic [31:0] hi;
    int          kind;

    start = 1'b1; A = 64'd100; B = 32'd7;
    repeat (3) @(negedge clk);
    #1;
    chk_zero("reset_state");
    start = 1'b0;
    rst = 1'b0;

    run_op(64'd100, 32'd7, 1'b0);
    run_op(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 1'b0);
    run_op(64'h1234_5678_9ABC_DEF0, 32'd0, 1'b0);
    run_op(64'h0000_0005_0000_0000, 32'd5, 1'b0);
    run_op(64'd0, 32'd1, 1'b0);
    run_op(64'h0000_0000_FFFF_FFFF, 32'd1, 1'b0);
    run_op(64'hFFFF_FFFE_FFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(64'h0000_0007_0000_0000, 32'd7, 1'b0);
    run_op(64'h0000_0006_FFFF_FFFF, 32'd7, 1'b1);

    // Abort mid-operation; start held with rst must be ignored
    issue(64'd100, 32'd7);
    @(negedge clk); #1;
    start = 1'b0;
    chk("busy_running", {63'd0, busy}, 64'd1);
    repeat (9) @(negedge clk);
    #1;
    rst = 1'b1; start = 1'b1; A = 64'd9; B = 32'd3;
    sb.delete();
    @(negedge clk); #1;
    rst = 1'b0; start = 1'b0;
    chk_zero("abort_reset");
    @(negedge clk); #1;
    chk_zero("after_abort");
    run_op(64'd9, 32'd3, 1'b0);

    for (int i = 0; i < 1200; i++) begin
      kind = int'($urandom_range(9, 0));
      b = $urandom;
      if (b == 32'd0) b = 32'd1;
      if (kind == 2) b = $urandom_range(16, 1);
      if (kind == 1) hi = $urandom_range(32'hFFFF_FFFF, b);
      else hi = $urandom_range(b - 32'd1, 0);
      if (kind == 0) b = 32'd0;
      run_op({hi, $urandom}, b, 1'($urandom_range(1, 0)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
